tag_fifo_mp: RTL and testbench

//   Multi-port free-tag FIFO for the superscalar dispatcher. Holds unallocated ROB/rename tags.

---
 rtl/tag_fifo_pkg.sv | 30 +++
 rtl/tag_fifo_mp_compact.sv | 39 +++
 rtl/tag_fifo_mp.sv | 159 +++++++++++++++
 tb/tb_tag_fifo_mp.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tag_fifo_pkg
// Description : Shared types, sizing constants and helpers for the free-tag
//               FIFO used by the superscalar dispatcher / ROB.
// Revision    : 1.0 - initial release
// ============================================================================
package tag_fifo_pkg;

  // Default sizing of the dispatcher's free-tag pool
  localparam int TAG_DEPTH = 64;
  localparam int TAG_WIDTH = 6;
  localparam int PTR_W     = $clog2(TAG_DEPTH) + 1;
  localparam int CNT_W     = PTR_W;

  // Tag type shared with the dispatcher and ROB
  typedef logic [TAG_WIDTH-1:0] tag_t;

  // Population count of up to four lane-valid bits (max return lanes is 4)
  function automatic logic [2:0] popcount(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tag_fifo_mp_compact.sv
`default_nettype none
// ============================================================================
// Module      : tag_lane_compact
// Description : Squeezes sparse CDB return lanes into a dense, lane-ordered
//               tag vector (lowest valid lane first) plus a count of valids.
// Revision    : 1.0 - initial release
// ============================================================================
module tag_lane_compact
  import tag_fifo_pkg::*;
#(
  parameter  int RET_W      = 2,
  parameter  int DATA_WIDTH = 6,
  localparam int C_NW_W     = $clog2(RET_W + 1)
) (
  input  logic [RET_W*DATA_WIDTH-1:0] lane_tag,
  input  logic [RET_W-1:0]            lane_vld,
  output logic [RET_W*DATA_WIDTH-1:0] tag_vec,
  output logic [C_NW_W-1:0]           tag_cnt
);

  int w_slot;

  // Each valid lane lands in the next free dense slot, preserving lane order
  always_comb begin
    tag_vec = '0;
    w_slot  = 0;
    for (int i = 0; i < RET_W; i++) begin
      if (lane_vld[i]) begin
        tag_vec[w_slot*DATA_WIDTH +: DATA_WIDTH] = lane_tag[i*DATA_WIDTH +: DATA_WIDTH];
        w_slot = w_slot + 1;
      end
    end
  end

  // Lane count is narrowed to the width needed for RET_W lanes
  assign tag_cnt = C_NW_W'(popcount(4'(lane_vld)));

endmodule
`default_nettype wire

// File: rtl/tag_fifo_mp.sv
`default_nettype none
// ============================================================================
// Module      : tag_fifo_mp
// Description : Multi-port free-tag FIFO. Hands out up to ALLOC_W head tags
//               per cycle (zero-latency read) and accepts up to RET_W
//               returned tags per cycle from the CDB. Provides occupancy,
//               full/empty, synchronous flush to the full free list and
//               sticky overflow/underflow error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tag_fifo_mp
  import tag_fifo_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 6,
  parameter int ALLOC_W    = 2,
  parameter int RET_W      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [RET_W*DATA_WIDTH-1:0]   cdb_tag_tf,
  input  logic [RET_W-1:0]              cdb_tag_tf_valid,
  input  logic [$clog2(ALLOC_W+1)-1:0]  ren_cnt_tf,
  input  logic                          flush_tf,
  output logic [ALLOC_W*DATA_WIDTH-1:0] tagout_tf,
  output logic [ALLOC_W-1:0]            tagout_vld_tf,
  output logic [$clog2(DEPTH):0]        cnt_tf,
  output logic                          ff_tf,
  output logic                          ef_tf,
  output logic                          ovf_err_tf,
  output logic                          udf_err_tf
);

  localparam int C_IDX_W = $clog2(DEPTH);
  localparam int C_PTR_W = C_IDX_W + 1;
  localparam int C_CNT_W = C_PTR_W;
  localparam int C_NW_W  = $clog2(RET_W + 1);
  // One extra bit so cnt + pushes never wraps while judging acceptance
  localparam int C_SUM_W = C_CNT_W + 1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_fifo [DEPTH];
  logic [C_PTR_W-1:0]    r_rp;
  logic [C_PTR_W-1:0]    r_wp;
  logic [C_CNT_W-1:0]    r_cnt;
  logic                  r_ovf;
  logic                  r_udf;

  // --------------------------------------------------------------------------
  // Return-lane compaction
  // --------------------------------------------------------------------------
  logic [RET_W*DATA_WIDTH-1:0] w_cmp_vec;
  logic [C_NW_W-1:0]           w_nwr;

  tag_lane_compact #(
    .RET_W      (RET_W),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_compact (
    .lane_tag (cdb_tag_tf),
    .lane_vld (cdb_tag_tf_valid),
    .tag_vec  (w_cmp_vec),
    .tag_cnt  (w_nwr)
  );

  // --------------------------------------------------------------------------
  // Pop / push acceptance
  // --------------------------------------------------------------------------
  logic               w_pop_ok;
  logic               w_push_ok;
  logic [C_SUM_W-1:0] w_cnt_ext;
  logic [C_SUM_W-1:0] w_ren_ext;
  logic [C_SUM_W-1:0] w_npop;
  logic [C_SUM_W-1:0] w_nwr_ext;
  logic [C_SUM_W-1:0] w_nwr_acc;
  logic [C_SUM_W-1:0] w_cnt_post;
  logic [C_SUM_W-1:0] w_cnt_next;

  // A pop is all-or-nothing; pushes are judged against the room left after the pop
  always_comb begin
    w_cnt_ext  = C_SUM_W'(r_cnt);
    w_ren_ext  = C_SUM_W'(ren_cnt_tf);
    w_nwr_ext  = C_SUM_W'(w_nwr);
    w_pop_ok   = (w_ren_ext <= w_cnt_ext);
    w_npop     = w_pop_ok ? w_ren_ext : '0;
    w_cnt_post = w_cnt_ext - w_npop + w_nwr_ext;
    w_push_ok  = (w_cnt_post <= C_SUM_W'(DEPTH));
    w_nwr_acc  = w_push_ok ? w_nwr_ext : '0;
    w_cnt_next = w_cnt_ext - w_npop + w_nwr_acc;
  end

  // Per-slot write address and enable for the compacted return tags
  logic [C_IDX_W-1:0] w_widx [RET_W];
  logic [RET_W-1:0]   w_wen;

  for (genvar gj = 0; gj < RET_W; gj++) begin : g_wr
    assign w_widx[gj] = C_IDX_W'(r_wp + C_PTR_W'(gj));
    assign w_wen[gj]  = w_push_ok && (int'(w_nwr) > gj);
  end

  // --------------------------------------------------------------------------
  // Sequential update: reset/flush reload the full free list 0..DEPTH-1
  // --------------------------------------------------------------------------
  // Storage, pointers, occupancy and sticky errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo[i] <= DATA_WIDTH'(i);
      end
      r_rp  <= '0;
      r_wp  <= C_PTR_W'(DEPTH);
      r_cnt <= C_CNT_W'(DEPTH);
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (flush_tf) begin
      // Same as reset except the error flags, which only rst clears
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo[i] <= DATA_WIDTH'(i);
      end
      r_rp  <= '0;
      r_wp  <= C_PTR_W'(DEPTH);
      r_cnt <= C_CNT_W'(DEPTH);
    end else begin
      for (int j = 0; j < RET_W; j++) begin
        if (w_wen[j]) begin
          r_fifo[w_widx[j]] <= w_cmp_vec[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      r_rp  <= r_rp + C_PTR_W'(w_npop);
      r_wp  <= r_wp + C_PTR_W'(w_nwr_acc);
      r_cnt <= C_CNT_W'(w_cnt_next);
      if (!w_pop_ok) begin
        r_udf <= 1'b1;
      end
      if (!w_push_ok) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Zero-latency read port: purely from registered rp/fifo/cnt
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < ALLOC_W; gi++) begin : g_slot
    logic [C_IDX_W-1:0] w_ridx;
    assign w_ridx = C_IDX_W'(r_rp + C_PTR_W'(gi));
    assign tagout_tf[gi*DATA_WIDTH +: DATA_WIDTH] = r_fifo[w_ridx];
    assign tagout_vld_tf[gi] = (C_SUM_W'(r_cnt) > C_SUM_W'(gi));
  end

  assign cnt_tf     = r_cnt;
  assign ff_tf      = (r_cnt == C_CNT_W'(DEPTH));
  assign ef_tf      = (r_cnt == '0);
  assign ovf_err_tf = r_ovf;
  assign udf_err_tf = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_tag_fifo_mp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_tag_fifo_mp
// Description : Self-checking bench for tag_fifo_mp. A queue holds the tags
//               the FIFO should contain; head slots are compared against it
//               before each pop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tag_fifo_mp;

  localparam int DEPTH = 64;
  localparam int DW    = 6;
  localparam int AW    = 2;
  localparam int RW    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [RW*DW-1:0]  cdb_tag_tf;
  logic [RW-1:0]     cdb_tag_tf_valid;
  logic [1:0]        ren_cnt_tf;
  logic              flush_tf;
  logic [AW*DW-1:0]  tagout_tf;
  logic [AW-1:0]     tagout_vld_tf;
  logic [6:0]        cnt_tf;
  logic              ff_tf;
  logic              ef_tf;
  logic              ovf_err_tf;
  logic              udf_err_tf;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected FIFO contents, head at index 0
  int q[$];
  bit m_ovf;
  bit m_udf;

  always #5 clk = ~clk;

  tag_fifo_mp #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW),
    .ALLOC_W    (AW),
    .RET_W      (RW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cdb_tag_tf       (cdb_tag_tf),
    .cdb_tag_tf_valid (cdb_tag_tf_valid),
    .ren_cnt_tf       (ren_cnt_tf),
    .flush_tf         (flush_tf),
    .tagout_tf        (tagout_tf),
    .tagout_vld_tf    (tagout_vld_tf),
    .cnt_tf           (cnt_tf),
    .ff_tf            (ff_tf),
    .ef_tf            (ef_tf),
    .ovf_err_tf       (ovf_err_tf),
    .udf_err_tf       (udf_err_tf)
  );

  function automatic int slot(input int i);
    return int'(tagout_tf[i*DW +: DW]);
  endfunction

  function automatic logic [1:0] exp_vld();
    return {q.size() > 1, q.size() > 0};
  endfunction

  task automatic idle_inputs();
    ren_cnt_tf       = '0;
    cdb_tag_tf_valid = '0;
    cdb_tag_tf       = '0;
    flush_tf         = 1'b0;
  endtask

  task automatic model_reset(input bit keep_err);
    q.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back(i);
    if (!keep_err) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
  endtask

  // Drive one cycle from a negedge, update the scoreboard at the posedge,
  // and return at the following negedge ready for sampling.
  task automatic drive(input int ren, input logic [1:0] vld, input int t0, input int t1, input bit fl);
    int npop;
    int nwr;
    ren_cnt_tf       = 2'(ren);
    cdb_tag_tf_valid = vld;
    cdb_tag_tf       = {6'(t1), 6'(t0)};
    flush_tf         = fl;
    @(posedge clk);
    if (fl) begin
      model_reset(1'b1);
    end else begin
      npop = (ren <= q.size()) ? ren : 0;
      if (ren > q.size()) m_udf = 1'b1;
      nwr = int'(vld[0]) + int'(vld[1]);
      repeat (npop) void'(q.pop_front());
      if (q.size() + nwr <= DEPTH) begin
        if (vld[0]) q.push_back(t0);
        if (vld[1]) q.push_back(t1);
      end else begin
        m_ovf = 1'b1;
      end
    end
    #1;
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset(1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (cnt_tf !== 7'd64 || ff_tf !== 1'b1 || ef_tf !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags cnt=%0d ff=%b ef=%b required cnt=64 ff=1 ef=0", cnt_tf, ff_tf, ef_tf);
    end
    checks++;
    if (tagout_tf !== {6'd1, 6'd0} || tagout_vld_tf !== 2'b11) begin
      errors++;
      $display("FAIL reset_tagout tag=%h vld=%b required tag=%h vld=11", tagout_tf, tagout_vld_tf, {6'd1, 6'd0});
    end
    checks++;
    if (ovf_err_tf !== 1'b0 || udf_err_tf !== 1'b0) begin
      errors++;
      $display("FAIL reset_err ovf=%b udf=%b required 0 0", ovf_err_tf, udf_err_tf);
    end
    rst = 1'b0;
    repeat (3) drive(0, 2'b00, 0, 0, 1'b0);
    checks++;
    if (cnt_tf !== 7'd64 || tagout_tf !== {6'd1, 6'd0} || tagout_vld_tf !== 2'b11) begin
      errors++;
      $display("FAIL hold_idle cnt=%0d tag=%h vld=%b required cnt=64 tag=%h vld=11", cnt_tf, tagout_tf, tagout_vld_tf, {6'd1, 6'd0});
    end
  endtask

  task automatic test_drain();
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (slot(0) !== q[0] || slot(1) !== q[1] || slot(0) !== 2*k || tagout_vld_tf !== 2'b11) begin
        errors++;
        $display("FAIL drain_head k=%0d got %0d,%0d vld=%b required %0d,%0d vld=11", k, slot(0), slot(1), tagout_vld_tf, 2*k, 2*k+1);
      end
      drive(2, 2'b00, 0, 0, 1'b0);
    end
    checks++;
    if (cnt_tf !== 7'd0 || ef_tf !== 1'b1 || ff_tf !== 1'b0 || tagout_vld_tf !== 2'b00) begin
      errors++;
      $display("FAIL drain_empty cnt=%0d ef=%b ff=%b vld=%b required 0 1 0 00", cnt_tf, ef_tf, ff_tf, tagout_vld_tf);
    end
    drive(1, 2'b00, 0, 0, 1'b0);
    checks++;
    if (udf_err_tf !== 1'b1 || cnt_tf !== 7'd0 || ovf_err_tf !== 1'b0) begin
      errors++;
      $display("FAIL underflow udf=%b cnt=%0d ovf=%b required 1 0 0", udf_err_tf, cnt_tf, ovf_err_tf);
    end
  endtask

  task automatic test_refill();
    drive(0, 2'b10, 0, 9, 1'b0);
    checks++;
    if (cnt_tf !== 7'd1 || slot(0) !== 9 || tagout_vld_tf !== 2'b01 || ef_tf !== 1'b0) begin
      errors++;
      $display("FAIL refill_one cnt=%0d head=%0d vld=%b ef=%b required 1 9 01 0", cnt_tf, slot(0), tagout_vld_tf, ef_tf);
    end
    drive(0, 2'b11, 5, 7, 1'b0);
    checks++;
    if (cnt_tf !== 7'd3 || slot(0) !== q[0] || slot(1) !== q[1] || slot(1) !== 5 || tagout_vld_tf !== 2'b11) begin
      errors++;
      $display("FAIL refill_two cnt=%0d head=%0d,%0d vld=%b required 3 9,5 11", cnt_tf, slot(0), slot(1), tagout_vld_tf);
    end
    drive(2, 2'b00, 0, 0, 1'b0);
    checks++;
    if (cnt_tf !== 7'd1 || slot(0) !== 7 || tagout_vld_tf !== exp_vld()) begin
      errors++;
      $display("FAIL refill_pop cnt=%0d head=%0d vld=%b required 1 7 %b", cnt_tf, slot(0), tagout_vld_tf, exp_vld());
    end
  endtask

  task automatic test_pop_push();
    drive(1, 2'b11, 11, 12, 1'b0);
    checks++;
    if (cnt_tf !== 7'd2 || slot(0) !== 11 || slot(1) !== 12 || ovf_err_tf !== 1'b0) begin
      errors++;
      $display("FAIL pop_push cnt=%0d head=%0d,%0d ovf=%b required 2 11,12 0", cnt_tf, slot(0), slot(1), ovf_err_tf);
    end
  endtask

  task automatic test_full();
    drive(0, 2'b00, 0, 0, 1'b1);
    checks++;
    if (cnt_tf !== 7'd64 || ff_tf !== 1'b1 || tagout_tf !== {6'd1, 6'd0} || udf_err_tf !== 1'b1) begin
      errors++;
      $display("FAIL flush_full cnt=%0d ff=%b tag=%h udf=%b required 64 1 %h 1", cnt_tf, ff_tf, tagout_tf, udf_err_tf, {6'd1, 6'd0});
    end
    drive(0, 2'b01, 33, 0, 1'b0);
    checks++;
    if (ovf_err_tf !== 1'b1 || cnt_tf !== 7'd64 || slot(0) !== 0) begin
      errors++;
      $display("FAIL overflow ovf=%b cnt=%0d head=%0d required 1 64 0", ovf_err_tf, cnt_tf, slot(0));
    end
    drive(2, 2'b11, 0, 1, 1'b0);
    checks++;
    if (cnt_tf !== 7'd64 || ff_tf !== 1'b1 || slot(0) !== 2 || slot(1) !== 3) begin
      errors++;
      $display("FAIL full_swap cnt=%0d ff=%b head=%0d,%0d required 64 1 2,3", cnt_tf, ff_tf, slot(0), slot(1));
    end
  endtask

  task automatic test_wrap();
    int t0;
    int t1;
    // Make rp/wp odd so a two-entry access straddles index 63 -> 0
    drive(1, 2'b01, 40, 0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      t0 = int'($urandom_range(63));
      t1 = int'($urandom_range(63));
      checks++;
      if (slot(0) !== q[0] || slot(1) !== q[1] || cnt_tf !== 7'(q.size())) begin
        errors++;
        $display("FAIL wrap_head k=%0d got %0d,%0d cnt=%0d required %0d,%0d cnt=%0d", k, slot(0), slot(1), cnt_tf, q[0], q[1], q.size());
      end
      drive(2, 2'b11, t0, t1, 1'b0);
    end
    // Drain across the wrap to expose every returned tag in order
    for (int k = 0; k < 31; k++) begin
      checks++;
      if (slot(0) !== q[0] || slot(1) !== q[1]) begin
        errors++;
        $display("FAIL wrap_drain k=%0d got %0d,%0d required %0d,%0d", k, slot(0), slot(1), q[0], q[1]);
      end
      drive(2, 2'b00, 0, 0, 1'b0);
    end
    checks++;
    if (cnt_tf !== 7'(q.size()) || tagout_vld_tf !== exp_vld()) begin
      errors++;
      $display("FAIL wrap_cnt cnt=%0d vld=%b required %0d %b", cnt_tf, tagout_vld_tf, q.size(), exp_vld());
    end
  endtask

  task automatic test_flush_mid();
    drive(2, 2'b11, 20, 21, 1'b1);
    checks++;
    if (cnt_tf !== 7'd64 || tagout_tf !== {6'd1, 6'd0} || ovf_err_tf !== m_ovf || udf_err_tf !== m_udf) begin
      errors++;
      $display("FAIL flush_mid cnt=%0d tag=%h ovf=%b udf=%b required 64 %h %b %b", cnt_tf, tagout_tf, ovf_err_tf, udf_err_tf, {6'd1, 6'd0}, m_ovf, m_udf);
    end
  endtask

  task automatic test_async_rst();
    drive(2, 2'b00, 0, 0, 1'b0);
    drive(2, 2'b00, 0, 0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset(1'b0);
    checks++;
    if (cnt_tf !== 7'd64 || tagout_tf !== {6'd1, 6'd0} || ovf_err_tf !== 1'b0 || udf_err_tf !== 1'b0) begin
      errors++;
      $display("FAIL async_rst cnt=%0d tag=%h ovf=%b udf=%b required 64 %h 0 0", cnt_tf, tagout_tf, ovf_err_tf, udf_err_tf, {6'd1, 6'd0});
    end
    @(negedge clk);
    rst = 1'b0;
    drive(2, 2'b00, 0, 0, 1'b0);
    checks++;
    if (slot(0) !== 2 || slot(1) !== 3 || cnt_tf !== 7'd62) begin
      errors++;
      $display("FAIL post_rst head=%0d,%0d cnt=%0d required 2,3 62", slot(0), slot(1), cnt_tf);
    end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_refill();
    test_pop_push();
    test_full();
    test_wrap();
    test_flush_mid();
    test_async_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
